// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - state encodings and handshake levels for the multi-cycle divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_ANNUL            = 1'b1;

endpackage

// File: rtl/div.sv
// rtl/div.sv - radix-2 restoring divider for DIV/DIVU, {remainder, quotient} result
// One quotient bit per clock; operands are captured only when idle.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W:0]   work_q;
  logic [DATA_W-1:0]   divisor_q;
  logic                neg_quot_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W:0]   work_d;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;

  // INT_MIN negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    diff   = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    work_d = diff[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                          : {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
    quot   = neg_quot_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem    = neg_rem_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && annul_i != DIV_ANNUL) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BY_ZERO;
            end else begin
              state_q    <= DIV_ON;
              cnt_q      <= '0;
              work_q     <= {{DATA_W{1'b0}}, abs_a, 1'b0};
              divisor_q  <= abs_b;
              neg_quot_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_q  <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          work_q   <= '0;
          result_q <= '0;
          ready_q  <= DIV_RESULT_READY;
          state_q  <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i == DIV_ANNUL) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
            work_q  <= '0;
            ready_q <= DIV_RESULT_NOT_READY;
          end else if (cnt_q != LAST_CNT) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            result_q <= {rem, quot};
            ready_q  <= DIV_RESULT_READY;
            cnt_q    <= '0;
            state_q  <= DIV_END;
          end
        end
        DIV_END: begin
          // Held start never re-launches; EX must drop it to release the result.
          if (start_i == DIV_STOP) begin
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            state_q  <= DIV_FREE;
          end
        end
        default: begin
          state_q <= DIV_FREE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - randomized self-checking bench for the divider
module tb_div;

  localparam int DATA_W = 32;

  logic                clk;
  logic                rst;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  int total;
  int bad;

  div #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    if (b == 32'd0) return 64'h0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int cyc);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!ready_o && cyc < 100);
    res = result_o;
  endtask

  task automatic test_one(input string name, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    logic [63:0] res;
    int cyc;
    int exp_lat;
    exp     = model(s, a, b);
    exp_lat = (b == 32'd0) ? 1 : DATA_W + 1;
    run_div(s, a, b, res, cyc);
    total++;
    if (cyc - 1 != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d edges after E0, want %0d", name, cyc - 1, exp_lat);
    end
    total++;
    if (res !== exp) begin
      bad++;
      $display("FAIL %s result: got %h want %h", name, res, exp);
    end
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      bad++;
      $display("FAIL %s hold: got ready=%b result=%h want ready=1 result=%h", name, ready_o, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      bad++;
      $display("FAIL %s drop: got ready=%b result=%h want ready=0 result=0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset;
    start_i      = 1'b1;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd2;
    signed_div_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
    start_i = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_directed;
    test_one("unsigned_100_7", 1'b0, 32'd100, 32'd7);
    test_one("signed_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    test_one("signed_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    test_one("by_zero", 1'b0, 32'h1234, 32'd0);
    test_one("intmin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    test_one("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    test_one("signed_by_zero", 1'b1, 32'h8000_0000, 32'd0);
  endtask

  task automatic test_annul;
    int seen;
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFF_FC18;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL annul_no_ready: ready seen %0d cycles, want 0", seen);
    end
    test_one("annul_next_5_3", 1'b0, 32'd5, 32'd3);
  endtask

  task automatic test_async_reset;
    logic [63:0] res;
    int cyc;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd9;
    start_i      = 1'b1;
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      bad++;
      $display("FAIL rst_mid_on: got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!ready_o && cyc < 100);
    total++;
    if (cyc - 1 != DATA_W + 1 || result_o !== model(1'b0, 32'd1000, 32'd9)) begin
      bad++;
      $display("FAIL rst_restart: got %0d edges result=%h want %0d edges result=%h",
               cyc - 1, result_o, DATA_W + 1, model(1'b0, 32'd1000, 32'd9));
    end
    start_i = 1'b0;
    @(posedge clk);
    run_div(1'b1, 32'hFFFF_FFCE, 32'd7, res, cyc);
    total++;
    if (ready_o !== 1'b1 || res !== model(1'b1, 32'hFFFF_FFCE, 32'd7)) begin
      bad++;
      $display("FAIL pre_rst_end: got ready=%b result=%h want ready=1 result=%h",
               ready_o, res, model(1'b1, 32'hFFFF_FFCE, 32'd7));
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      bad++;
      $display("FAIL rst_in_end: got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      test_one("random", s, a, b);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_annul();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
